// File: rtl/uart_fb_writer.sv
// Byte-stream command parser feeding a frame-buffer write port and returning ACK/NAK.
// Optional macro UART_FB_CHECKSUM_EN adds a trailing XOR checksum byte to pixel write runs.
module uart_fb_writer #(
   parameter int         PIXEL_W  = 3,
   parameter int         WIDTH    = 640,
   parameter int         HEIGHT   = 480,
   parameter int         ADDR_W   = 19,
   parameter logic [7:0] ACK_BYTE = 8'h06,
   parameter logic [7:0] NAK_BYTE = 8'h15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [PIXEL_W-1:0] fb_wdata,
   input  logic               fb_ready,
   output logic               tx_valid,
   output logic [7:0]         tx_data,
   input  logic               tx_ready,
   output logic               busy,
   output logic               overrun,
   input  logic               clr_overrun,
   output logic               frame_done,
   output logic [ADDR_W-1:0]  pixel_ptr
);

   localparam int                MAX  = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX - 1);

`ifdef UART_FB_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CNT, S_DATA, S_WR, S_FILL, S_CSUM, S_ANSWER} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CNT, S_DATA, S_WR, S_FILL, S_ANSWER} state_t;
`endif

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    ptr_q, ptr_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [23:0]          acc_q, acc_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [PIXEL_W-1:0]   pix_q, pix_d;
   logic                 fill_q, fill_d;
   logic [7:0]           ans_q, ans_d;
   logic                 overrun_q, overrun_d;
`ifdef UART_FB_CHECKSUM_EN
   logic [7:0]           csum_q, csum_d;
`endif

   logic                 wr_acc;
   logic                 ov_set;
   logic [ADDR_W-1:0]    ptr_inc;
   logic [23:0]          addr_val;
   logic [15:0]          cnt_val;

   assign fb_we      = (state_q == S_WR) || (state_q == S_FILL);
   assign fb_addr    = ptr_q;
   assign fb_wdata   = pix_q;
   assign tx_valid   = (state_q == S_ANSWER);
   assign tx_data    = ans_q;
   assign busy       = (state_q != S_IDLE);
   assign overrun    = overrun_q;
   assign pixel_ptr  = ptr_q;
   assign wr_acc     = fb_we && fb_ready;
   assign ptr_inc    = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
   assign frame_done = wr_acc && (ptr_q == LAST);
   assign addr_val   = {acc_q[15:0], rx_data};
   assign cnt_val    = {acc_q[7:0], rx_data};

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      byte_cnt_d = byte_cnt_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      pix_d      = pix_q;
      fill_d     = fill_q;
      ans_d      = ans_q;
      ov_set     = 1'b0;
`ifdef UART_FB_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               byte_cnt_d = '0;
               acc_d      = '0;
               fill_d     = 1'b0;
`ifdef UART_FB_CHECKSUM_EN
               csum_d     = rx_data;
`endif
               case (rx_data)
                  8'h01: begin
                     ptr_d   = '0;
                     ans_d   = ACK_BYTE;
                     state_d = S_ANSWER;
                  end
                  8'h02: state_d = S_ADDR;
                  8'h03: state_d = S_CNT;
                  8'h04: begin
                     fill_d  = 1'b1;
                     state_d = S_DATA;
                  end
                  default: begin
                     ans_d   = NAK_BYTE;
                     state_d = S_ANSWER;
                  end
               endcase
            end
         end
         S_ADDR: begin
            if (rx_valid) begin
               acc_d      = addr_val;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd2) begin
                  state_d = S_ANSWER;
                  // Out-of-range addresses leave the pointer where it was.
                  if ({8'h00, addr_val} < 32'(MAX)) begin
                     ptr_d = ADDR_W'(addr_val);
                     ans_d = ACK_BYTE;
                  end else begin
                     ans_d = NAK_BYTE;
                  end
               end
            end
         end
         S_CNT: begin
            if (rx_valid) begin
               acc_d      = {acc_q[15:0], rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_FB_CHECKSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               if (byte_cnt_q == 2'd1) begin
                  cnt_d = cnt_val;
                  if (cnt_val != 16'd0) begin
                     state_d = S_DATA;
                  end else begin
`ifdef UART_FB_CHECKSUM_EN
                     state_d = S_CSUM;
`else
                     ans_d   = ACK_BYTE;
                     state_d = S_ANSWER;
`endif
                  end
               end
            end
         end
         S_DATA: begin
            // Shared by write runs (pixel bytes) and fill (single colour byte).
            if (rx_valid) begin
               pix_d = rx_data[PIXEL_W-1:0];
`ifdef UART_FB_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               if (fill_q) begin
                  ptr_d   = '0;
                  state_d = S_FILL;
               end else begin
                  state_d = S_WR;
               end
            end
         end
         S_WR: begin
            ov_set = rx_valid;
            if (wr_acc) begin
               ptr_d = ptr_inc;
               cnt_d = cnt_q - 16'd1;
               if (cnt_q == 16'd1) begin
`ifdef UART_FB_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  ans_d   = ACK_BYTE;
                  state_d = S_ANSWER;
`endif
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_FILL: begin
            ov_set = rx_valid;
            if (wr_acc) begin
               ptr_d = ptr_inc;
               if (ptr_q == LAST) begin
                  ans_d   = ACK_BYTE;
                  state_d = S_ANSWER;
               end
            end
         end
`ifdef UART_FB_CHECKSUM_EN
         S_CSUM: begin
            if (rx_valid) begin
               ans_d   = (rx_data == csum_q) ? ACK_BYTE : NAK_BYTE;
               state_d = S_ANSWER;
            end
         end
`endif
         S_ANSWER: begin
            ov_set = rx_valid;
            if (tx_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      overrun_d = clr_overrun ? 1'b0 : (ov_set ? 1'b1 : overrun_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         byte_cnt_q <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         pix_q      <= '0;
         fill_q     <= 1'b0;
         ans_q      <= '0;
         overrun_q  <= 1'b0;
`ifdef UART_FB_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         byte_cnt_q <= byte_cnt_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         pix_q      <= pix_d;
         fill_q     <= fill_d;
         ans_q      <= ans_d;
         overrun_q  <= overrun_d;
`ifdef UART_FB_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_fb_writer.sv
// Directed bench for uart_fb_writer on a 10x6 frame; a queue model predicts writes and answers.
// Build with UART_FB_CHECKSUM_EN defined to exercise the checksum variant.
module tb_uart_fb_writer;

   localparam int PW  = 3;
   localparam int W   = 10;
   localparam int H   = 6;
   localparam int AW  = 6;
   localparam int MAX = W * H;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   logic          clk, rst_n;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [PW-1:0] fb_wdata;
   logic          fb_ready;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          tx_ready;
   logic          busy, overrun, clr_overrun, frame_done;
   logic [AW-1:0] pixel_ptr;

   uart_fb_writer #(
      .PIXEL_W(PW), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW),
      .ACK_BYTE(ACK), .NAK_BYTE(NAK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_ready(fb_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun),
      .frame_done(frame_done), .pixel_ptr(pixel_ptr)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [AW-1:0] exp_addr_q[$];
   logic [PW-1:0] exp_data_q[$];
   logic [7:0]    exp_ans_q[$];
   logic [7:0]    run_q[$];
   int            model_ptr = 0;
   int            fd_count  = 0;
   logic          toggle    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // clock / reset / ready generators
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      fb_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         fb_ready = toggle ? ~fb_ready : 1'b1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // scoreboard / compare process
   initial begin
      logic [AW-1:0] a;
      logic [PW-1:0] d;
      logic [7:0]    ans;
      logic          prev_hs;
      prev_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (fb_we && fb_ready) begin
               if (exp_addr_q.size() == 0) begin
                  check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
               end else begin
                  a = exp_addr_q.pop_front();
                  d = exp_data_q.pop_front();
                  check("wr_addr", 32'(fb_addr), 32'(a));
                  check("wr_data", 32'(fb_wdata), 32'(d));
                  check("wr_frame_done", 32'(frame_done), 32'(a == AW'(MAX - 1)));
               end
            end else if (frame_done) begin
               check("stray_frame_done", 32'(frame_done), 32'd0);
            end
            if (frame_done) fd_count++;
            if (prev_hs) check("tx_valid_drop", 32'(tx_valid), 32'd0);
            prev_hs = 1'b0;
            if (tx_valid && tx_ready) begin
               prev_hs = 1'b1;
               if (exp_ans_q.size() == 0) begin
                  check("unexpected_answer", 32'(tx_data), 32'hFFFF_FFFF);
               end else begin
                  ans = exp_ans_q.pop_front();
                  check("tx_data", 32'(tx_data), 32'(ans));
               end
            end
         end
      end
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (n < 2000 && (exp_ans_q.size() != 0 || exp_addr_q.size() != 0 || busy)) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check({name, "_done"}, 32'(n < 2000), 32'd1);
      check({name, "_ptr"}, 32'(pixel_ptr), 32'(model_ptr));
   endtask

   task automatic cmd_reset_ptr();
      exp_ans_q.push_back(ACK);
      model_ptr = 0;
      send_byte(8'h01);
   endtask

   task automatic cmd_set_addr(input logic [23:0] v);
      if (int'(v) < MAX) begin
         exp_ans_q.push_back(ACK);
         model_ptr = int'(v);
      end else begin
         exp_ans_q.push_back(NAK);
      end
      send_byte(8'h02);
      send_byte(v[23:16]);
      send_byte(v[15:8]);
      send_byte(v[7:0]);
   endtask

   // Pixel run over run_q; bad_csum corrupts the trailing checksum when it exists.
   task automatic write_run(input logic bad_csum);
      logic [15:0] n;
      logic [7:0]  cs;
      n  = 16'(run_q.size());
      cs = 8'h03 ^ n[15:8] ^ n[7:0];
      foreach (run_q[i]) begin
         cs = cs ^ run_q[i];
         exp_addr_q.push_back(AW'(model_ptr));
         exp_data_q.push_back(PW'(run_q[i] % (1 << PW)));
         model_ptr = (model_ptr + 1) % MAX;
      end
`ifdef UART_FB_CHECKSUM_EN
      exp_ans_q.push_back(bad_csum ? NAK : ACK);
`else
      exp_ans_q.push_back(ACK);
`endif
      send_byte(8'h03);
      send_byte(n[15:8]);
      send_byte(n[7:0]);
      foreach (run_q[i]) send_byte(run_q[i]);
`ifdef UART_FB_CHECKSUM_EN
      send_byte(bad_csum ? (cs ^ 8'h07) : cs);
`else
      if (bad_csum) cs = ~cs;
`endif
   endtask

   task automatic cmd_fill_with_overrun(input logic [7:0] colour);
      for (int i = 0; i < MAX; i++) begin
         exp_addr_q.push_back(AW'(i));
         exp_data_q.push_back(PW'(colour % (1 << PW)));
      end
      exp_ans_q.push_back(ACK);
      model_ptr = 0;
      send_byte(8'h04);
      send_byte(colour);
      send_byte(8'hAA);
   endtask

   // directed sequence
   initial begin
      int fd0;
      int ptr_after_bad;
      rst_n       = 1'b0;
      rx_data     = 8'h00;
      rx_valid    = 1'b0;
      tx_ready    = 1'b1;
      clr_overrun = 1'b0;
      #12;
      check("reset_outputs",
            32'({fb_we, tx_valid, busy, overrun, frame_done, pixel_ptr, fb_addr, fb_wdata, tx_data}),
            32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      cmd_reset_ptr();
      wait_idle("ptr_reset");
      check("busy_after_ack", 32'(busy), 32'd0);

      cmd_set_addr(24'd30);
      wait_idle("set_addr_30");
      run_q = '{8'h05, 8'h07};
      write_run(1'b0);
      wait_idle("run_two");
      check("ptr_after_run", 32'(pixel_ptr), 32'd32);
`ifdef UART_FB_CHECKSUM_EN
      write_run(1'b1);
      wait_idle("run_bad_csum");
      ptr_after_bad = 34;
`else
      ptr_after_bad = 32;
`endif

      cmd_set_addr(24'd60);
      wait_idle("set_addr_oob");
      check("ptr_unchanged_oob", 32'(pixel_ptr), 32'(ptr_after_bad));

      cmd_set_addr(24'd59);
      wait_idle("set_addr_last");
      fd0   = fd_count;
      run_q = '{8'hFD, 8'h01};
      write_run(1'b0);
      wait_idle("run_wrap");
      check("wrap_frame_done_once", 32'(fd_count - fd0), 32'd1);
      check("ptr_after_wrap", 32'(pixel_ptr), 32'd1);

      run_q.delete();
      write_run(1'b0);
      wait_idle("run_zero");

      check("overrun_before_fill", 32'(overrun), 32'd0);
      toggle = 1'b1;
      fd0    = fd_count;
      cmd_fill_with_overrun(8'h02);
      wait_idle("fill");
      toggle = 1'b0;
      check("fill_frame_done_once", 32'(fd_count - fd0), 32'd1);
      check("fill_ptr_zero", 32'(pixel_ptr), 32'd0);
      check("overrun_set", 32'(overrun), 32'd1);
      @(posedge clk);
      #1 clr_overrun = 1'b1;
      @(posedge clk);
      #1 clr_overrun = 1'b0;
      @(negedge clk);
      check("overrun_cleared", 32'(overrun), 32'd0);

      cmd_set_addr(24'd7);
      wait_idle("set_addr_7");
      cmd_reset_ptr();
      wait_idle("ptr_reset_again");
      check("ptr_zero_literal", 32'(pixel_ptr), 32'd0);

      tx_ready = 1'b0;
      exp_ans_q.push_back(NAK);
      send_byte(8'hFF);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_tx_valid", 32'(tx_valid), 32'd1);
         check("hold_tx_data", 32'(tx_data), 32'(NAK));
      end
      @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_idle("nak_unknown");

      cmd_set_addr(24'd12);
      wait_idle("set_addr_12");
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h05);
      check("busy_mid_run", 32'(busy), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_reset_outputs",
            32'({fb_we, tx_valid, busy, overrun, frame_done, pixel_ptr}), 32'd0);
      model_ptr = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("no_answer_after_reset", 32'(exp_ans_q.size()), 32'd0);
      check("idle_after_reset", 32'({busy, tx_valid, pixel_ptr}), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_fb_writer.md
Name: uart_fb_writer

Overview:
- Byte-stream command parser between the UART receiver and the frame-buffer RAM write port.
- Decodes a small packet protocol: pointer reset, set address, pixel write run, full-frame fill.
- Writes PIXEL_W-bit pixels with backpressure and returns a one-byte answer (ACK/NAK) to the UART transmitter.
- Generalised successor of the fixed 3-bit, 640x480, write-only UART-to-framebuffer path.

Parameters:
- PIXEL_W, 3: pixel width in bits; taken from the low bits of each data byte; valid range 1..8.
- WIDTH, 640: frame width in pixels.
- HEIGHT, 480: frame height in pixels.
- ADDR_W, 19: frame-buffer address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT.
- ACK_BYTE, 8'h06: answer byte for success.
- NAK_BYTE, 8'h15: answer byte for error or unknown command.

Ports:
- clk  in  1  single clock (system clock domain).
- rst_n  in  1  asynchronous reset, active-low.
- rx_data  in  8  received byte from the UART controller.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- fb_we  out  1  frame-buffer write request.
- fb_addr  out  ADDR_W  write address.
- fb_wdata  out  PIXEL_W  write data.
- fb_ready  in  1  write accepted in any cycle where fb_we=1 and fb_ready=1.
- tx_valid  out  1  answer byte valid.
- tx_data  out  8  answer byte.
- tx_ready  in  1  transmitter accepts the byte.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; a byte arrived that could not be absorbed.
- clr_overrun  in  1  synchronous clear of overrun.
- frame_done  out  1  one-cycle pulse when the pointer wraps from WIDTH*HEIGHT-1 to 0.
- pixel_ptr  out  ADDR_W  current write pointer.

Behaviour:
- Reset values: all outputs 0; pointer 0; state IDLE. Asserting reset mid-packet abandons the packet without emitting an answer.
- MAX = WIDTH*HEIGHT. Pointer increments on each accepted write. At MAX-1 it wraps to 0, and frame_done pulses in the same cycle as the wrapping write.
- States: IDLE, ADDR, CNT, DATA, WR, FILL, CSUM (macro only), ANSWER.
- IDLE decodes each command byte:
  - 0x01: pointer <= 0, then ANSWER(ACK).
  - 0x02: go to ADDR.
  - 0x03: go to CNT.
  - 0x04: go to FILL after one colour byte.
  - Any other byte: ANSWER(NAK).
- ADDR: collects 3 bytes, big-endian, into a 24-bit value.
  - Value < MAX: pointer <= value, then ACK.
  - Value >= MAX: pointer unchanged, then NAK.
- CNT: collects a 2-byte big-endian count N.
  - N=0: ACK immediately.
  - Otherwise go to DATA.
- DATA/WR: each data byte is latched, then fb_we=1 with fb_addr=pointer and fb_wdata=byte[PIXEL_W-1:0].
  - fb_we is held until fb_ready. Latency from rx_valid to first fb_we is 1 cycle.
  - After the Nth accepted write: ACK (or CSUM with the macro).
- FILL: the colour byte is latched, then one write is issued per fb_ready cycle for addresses 0..MAX-1.
  - Starts at address 0 regardless of pointer.
  - The pointer is left at 0 and frame_done pulses once.
  - Then ACK.
- ANSWER: tx_valid=1 with tx_data held stable until tx_ready; then IDLE. tx_valid deasserts the cycle after the handshake.
- Overrun: rx_valid in WR, FILL or ANSWER sets overrun and drops the byte; the packet continues. Writes that have already been accepted are not undone.
- clr_overrun wins over a simultaneous set.
- The pointer is never ≥ MAX.

Optional Feature:
- Macro: UART_FB_CHECKSUM_EN.
- Defined: WRITE_RUN expects one extra byte after the N data bytes, equal to the XOR of the command byte, both count bytes and all data bytes.
  - Match gives ACK; mismatch gives NAK. Pixels are already written either way.
  - N=0 also expects the checksum byte.
- Undefined: no CSUM state; WRITE_RUN answers immediately after the last write.

Test Plan:
- Reset, then send 0x01 -> pixel_ptr=0, one tx handshake with tx_data=0x06, busy returns to 0.
- Send 0x02 00 01 2C, then 0x03 00 02 05 07 -> writes (300,5), (301,7); pixel_ptr=302; ACK. With the macro, checksum byte 0x03^0x00^0x02^0x05^0x07=0x03 -> ACK, and 0x04 -> NAK.
- Send 0x02 04 B0 00 (307200) -> NAK, pointer unchanged. Then set address 307199 and write 2 pixels -> addresses 307199, 0; frame_done pulses once; pixel_ptr=1.
- Send 0x04 02 with fb_ready toggling every other cycle -> exactly 307200 writes of 2, frame_done once, ACK; an extra rx byte during the fill sets overrun.
- Send 0xFF -> NAK. Hold tx_ready=0 for 10 cycles -> tx_valid and tx_data stay stable. Assert rst_n=0 during a 0x03 run -> outputs 0, no answer sent.
